alu_sequencer: RTL and testbench

//  Issue-side controller for the ALU's shared-bus interface. Accepts an ALU operation by valid/ready

---
 rtl/alu_sequencer.sv | 142 ++++++++++++++
 tb/tb_alu_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// ALU issue sequencer: accepts one op, walks the ALU through READ then WRITE, and returns its result.
// Latency: 3 cycles from accept to rsp_valid for a normal op, 1 cycle for divide-by-zero.
// Backpressure: one op in flight; req_ready is low until the response is taken with rsp_ready.
//
// Ports:
//   clk, rst_n                      clock (acts on posedge), async active-low reset
//   req_valid/req_ready/req_*       operation request handshake with mode and operands
//   rsp_valid/rsp_ready/rsp_*       result handshake with result and divide-by-zero error
//   flag_carry, flag_zero           architectural flags, written only by ADD/SUB/CMP
//   alu_a/alu_b/alu_mode/alu_control  drive the ALU's shared-bus interface
//   alu_out/alu_overflow/alu_zero   ALU results, valid while alu_control is REG_OP_WRITE

package alu_sequencer_pkg;

  typedef enum logic [3:0] {
    ALU_OP_ADD = 4'd0,
    ALU_OP_SUB = 4'd1,
    ALU_OP_MUL = 4'd2,
    ALU_OP_DIV = 4'd3,
    ALU_OP_AND = 4'd4,
    ALU_OP_OR  = 4'd5,
    ALU_OP_XOR = 4'd6,
    ALU_OP_NOT = 4'd7,
    ALU_OP_CMP = 4'd8
  } alu_op_t;

  typedef enum logic [1:0] {
    REG_OP_NONE  = 2'd0,
    REG_OP_READ  = 2'd1,
    REG_OP_WRITE = 2'd2
  } reg_op_t;

endpackage

module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  alu_op_t          req_mode,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_div0,
  output logic             flag_carry,
  output logic             flag_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output alu_op_t          alu_mode,
  output reg_op_t          alu_control,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_overflow,
  input  logic             alu_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EXEC = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state;

  // Only these modes produce meaningful ALU flag outputs; everything else leaves them floating.
  logic flags_defined;
  assign flags_defined = (alu_mode == ALU_OP_ADD) || (alu_mode == ALU_OP_SUB) ||
                         (alu_mode == ALU_OP_CMP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_result  <= '0;
      rsp_div0    <= 1'b0;
      flag_carry  <= 1'b0;
      flag_zero   <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_mode    <= ALU_OP_NOT;
      alu_control <= REG_OP_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            alu_a     <= req_a;
            alu_b     <= req_b;
            alu_mode  <= req_mode;
            req_ready <= 1'b0;
            // Divide-by-zero is answered locally; the ALU is never started for it.
            if (req_mode == ALU_OP_DIV && req_b == '0) begin
              rsp_result <= '1;
              rsp_div0   <= 1'b1;
              rsp_valid  <= 1'b1;
              state      <= DONE;
            end else begin
              alu_control <= REG_OP_READ;
              state       <= LOAD;
            end
          end
        end
        LOAD: begin
          // The ALU took the operands on the negedge inside LOAD; now let it drive the bus.
          alu_control <= REG_OP_WRITE;
          state       <= EXEC;
        end
        EXEC: begin
          alu_control <= REG_OP_NONE;
          rsp_result  <= alu_out;
          rsp_div0    <= 1'b0;
          rsp_valid   <= 1'b1;
          if (flags_defined) begin
            flag_carry <= alu_overflow;
            flag_zero  <= alu_zero;
          end
          state <= DONE;
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          alu_control <= REG_OP_NONE;
          rsp_valid   <= 1'b0;
          req_ready   <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: attaches an ALU model to the shared-bus side and checks every cycle
// against a transaction-level expectation (phase counted since accept), plus literal spot values.
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  alu_op_t    req_mode;
  logic [7:0] req_a, req_b;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_result;
  logic       rsp_div0;
  logic       flag_carry, flag_zero;
  logic [7:0] alu_a, alu_b;
  alu_op_t    alu_mode;
  reg_op_t    alu_control;
  logic [7:0] alu_out;
  logic       alu_overflow, alu_zero;

  alu_sequencer #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_div0(rsp_div0),
    .flag_carry(flag_carry), .flag_zero(flag_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode), .alu_control(alu_control),
    .alu_out(alu_out), .alu_overflow(alu_overflow), .alu_zero(alu_zero)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Plain arithmetic reference: returns {carry, zero, out[7:0]}.
  function automatic logic [9:0] ref_alu(input alu_op_t m, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] w;
    logic [7:0] o;
    w = '0;
    case (m)
      ALU_OP_ADD: w = {1'b0, a} + {1'b0, b};
      ALU_OP_SUB: w = {1'b0, a} - {1'b0, b};
      ALU_OP_CMP: w = {1'b0, a} - {1'b0, b};
      ALU_OP_MUL: w = {1'b0, 8'(a * b)};
      ALU_OP_DIV: w = (b == 8'h00) ? 9'h0FF : {1'b0, 8'(a / b)};
      ALU_OP_AND: w = {1'b0, a & b};
      ALU_OP_OR:  w = {1'b0, a | b};
      ALU_OP_XOR: w = {1'b0, a ^ b};
      ALU_OP_NOT: w = {1'b0, ~a};
      default:    w = '0;
    endcase
    o = (m == ALU_OP_CMP) ? a : w[7:0];
    return {w[8], (w[7:0] == 8'h00), o};
  endfunction

  function automatic bit sets_flags(input alu_op_t m);
    return (m == ALU_OP_ADD) || (m == ALU_OP_SUB) || (m == ALU_OP_CMP);
  endfunction

  // Expected architectural state, owned by the monitor.
  bit         exp_carry, exp_zero;
  logic [7:0] exp_a, exp_b;
  alu_op_t    exp_mode;

  // ALU model on the bus: captures on the negedge while READ, drives results while WRITE.
  logic [7:0] cap_a, cap_b;
  alu_op_t    cap_mode = ALU_OP_NOT;
  logic [9:0] alu_r;

  always @(negedge clk)
    if (alu_control == REG_OP_READ) begin
      cap_a    <= alu_a;
      cap_b    <= alu_b;
      cap_mode <= alu_mode;
    end

  always_comb begin
    alu_r        = ref_alu(cap_mode, cap_a, cap_b);
    alu_out      = 8'hA5;
    alu_overflow = 1'b0;
    alu_zero     = 1'b0;
    if (alu_control == REG_OP_WRITE) begin
      alu_out = alu_r[7:0];
      if (sets_flags(cap_mode)) begin
        alu_overflow = alu_r[9];
        alu_zero     = alu_r[8];
      end else begin
        // Undefined flag outputs: present the opposite of the held flags so any capture shows.
        alu_overflow = ~exp_carry;
        alu_zero     = ~exp_zero;
      end
    end
  end

  // Transaction-level expectation: phase k counts cycles since the accept edge.
  int         cyc = 0;
  bit         busy = 0;
  int         k = 0;
  bit         m_div0, m_upd;
  logic [7:0] m_res;
  logic [9:0] m_r;
  int         dut_hs = 0;
  int         accept_q[$];

  always @(negedge clk) begin
    bit      e_valid;
    reg_op_t e_ctrl;
    cyc++;
    if (!rst_n) begin
      busy = 0; k = 0;
      exp_carry = 0; exp_zero = 0;
      exp_a = '0; exp_b = '0; exp_mode = ALU_OP_NOT;
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_result", 32'(rsp_result), 32'd0);
      check("rst_rsp_div0", 32'(rsp_div0), 32'd0);
      check("rst_control", 32'(alu_control), 32'(REG_OP_NONE));
      check("rst_flags", 32'({flag_carry, flag_zero}), 32'd0);
      check("rst_alu_ab", 32'({alu_a, alu_b}), 32'd0);
      check("rst_alu_mode", 32'(alu_mode), 32'(ALU_OP_NOT));
    end else begin
      if (busy) k++;
      e_valid = busy && (m_div0 ? (k >= 1) : (k >= 3));
      e_ctrl  = REG_OP_NONE;
      if (busy && !m_div0 && k == 1) e_ctrl = REG_OP_READ;
      if (busy && !m_div0 && k == 2) e_ctrl = REG_OP_WRITE;
      if (busy && !m_div0 && k == 3 && m_upd) begin
        exp_carry = m_r[9];
        exp_zero  = m_r[8];
      end
      check("req_ready", 32'(req_ready), 32'(!busy));
      check("rsp_valid", 32'(rsp_valid), 32'(e_valid));
      check("alu_control", 32'(alu_control), 32'(e_ctrl));
      check("flag_carry", 32'(flag_carry), 32'(exp_carry));
      check("flag_zero", 32'(flag_zero), 32'(exp_zero));
      check("alu_ab", 32'({alu_a, alu_b}), 32'({exp_a, exp_b}));
      check("alu_mode", 32'(alu_mode), 32'(exp_mode));
      if (e_valid) begin
        check("rsp_result", 32'(rsp_result), 32'(m_res));
        check("rsp_div0", 32'(rsp_div0), 32'(m_div0));
      end
      if (rsp_valid && rsp_ready) dut_hs++;
      // What the coming posedge does.
      if (e_valid && rsp_ready) begin
        busy = 0;
      end else if (!busy && req_valid) begin
        busy     = 1; k = 0;
        exp_a    = req_a; exp_b = req_b; exp_mode = req_mode;
        m_r      = ref_alu(req_mode, req_a, req_b);
        m_div0   = (req_mode == ALU_OP_DIV) && (req_b == 8'h00);
        m_res    = m_r[7:0];
        m_upd    = sets_flags(req_mode);
        accept_q.push_back(cyc);
      end
    end
  end

  // Random response backpressure, enabled only in the random phase.
  bit rand_rdy = 0;
  always @(posedge clk)
    if (rand_rdy) begin
      #1 rsp_ready = ($urandom_range(0, 2) != 0);
    end

  // Issue one op and wait for its response; latency counts negedges after the accept edge.
  task automatic do_op(input alu_op_t m, input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] res, output logic d0, output int lat);
    int guard;
    @(posedge clk); #1;
    req_valid = 1; req_mode = m; req_a = a; req_b = b;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
    if (guard >= 50) check("accept_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    req_valid = 0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 50);
    if (lat >= 50) check("rsp_timeout", 32'd1, 32'd0);
    res = rsp_result;
    d0  = rsp_div0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] res;
    logic       d0;
    int         lat;
    int         hs0;
    int         guard;
    alu_op_t    b2b_m[3];
    logic [7:0] b2b_a[3], b2b_b[3];

    rst_n = 0; req_valid = 0; req_mode = ALU_OP_ADD; req_a = '0; req_b = '0; rsp_ready = 1;
    repeat (2) @(negedge clk);
    #1 rst_n = 1;

    // 1. ADD with carry out
    do_op(ALU_OP_ADD, 8'hF0, 8'h20, res, d0, lat);
    check("add_result", 32'(res), 32'h10);
    check("add_latency", 32'(lat), 32'd3);
    check("add_flags", 32'({flag_carry, flag_zero}), 32'b10);

    // 2. SUB to zero, then XOR leaves the flags alone
    do_op(ALU_OP_SUB, 8'h05, 8'h05, res, d0, lat);
    check("sub_result", 32'(res), 32'h00);
    check("sub_flags", 32'({flag_carry, flag_zero}), 32'b01);
    do_op(ALU_OP_XOR, 8'h0F, 8'hFF, res, d0, lat);
    check("xor_result", 32'(res), 32'hF0);
    check("xor_flags", 32'({flag_carry, flag_zero}), 32'b01);

    // 3. Divide by zero, then a real divide
    do_op(ALU_OP_DIV, 8'h09, 8'h00, res, d0, lat);
    check("div0_result", 32'(res), 32'hFF);
    check("div0_flag", 32'(d0), 32'd1);
    check("div0_latency", 32'(lat), 32'd1);
    check("div0_flags", 32'({flag_carry, flag_zero}), 32'b01);
    do_op(ALU_OP_DIV, 8'h09, 8'h03, res, d0, lat);
    check("div_result", 32'(res), 32'h03);
    check("div_flag", 32'(d0), 32'd0);

    // 4. CMP with borrow, response held off for 5 cycles
    @(posedge clk); #1 rsp_ready = 0;
    do_op(ALU_OP_CMP, 8'h03, 8'h07, res, d0, lat);
    check("cmp_result", 32'(res), 32'h03);
    check("cmp_flags", 32'({flag_carry, flag_zero}), 32'b10);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_result", 32'(rsp_result), 32'h03);
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1 rsp_ready = 1;

    // 5. Reset in the middle of EXEC of a MUL
    hs0 = dut_hs;
    @(posedge clk); #1;
    req_valid = 1; req_mode = ALU_OP_MUL; req_a = 8'h04; req_b = 8'h05;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
    @(posedge clk); #1 req_valid = 0;
    guard = 0;
    @(negedge clk);
    while (alu_control != REG_OP_WRITE && guard < 10) begin @(negedge clk); guard++; end
    check("mul_reached_exec", 32'(alu_control), 32'(REG_OP_WRITE));
    hs0 = dut_hs;
    #1 rst_n = 0;
    #1;
    check("abort_control", 32'(alu_control), 32'(REG_OP_NONE));
    check("abort_flags", 32'({flag_carry, flag_zero}), 32'b00);
    check("abort_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    #1 rst_n = 1;
    repeat (4) @(negedge clk);
    check("abort_no_rsp", 32'(dut_hs - hs0), 32'd0);
    do_op(ALU_OP_ADD, 8'h12, 8'h34, res, d0, lat);
    check("post_rst_add", 32'(res), 32'h46);
    check("post_rst_flags", 32'({flag_carry, flag_zero}), 32'b00);

    // 6. Back-to-back requests with req_valid held high
    b2b_m[0] = ALU_OP_ADD; b2b_a[0] = 8'h01; b2b_b[0] = 8'h02;
    b2b_m[1] = ALU_OP_SUB; b2b_a[1] = 8'h09; b2b_b[1] = 8'h04;
    b2b_m[2] = ALU_OP_AND; b2b_a[2] = 8'hF0; b2b_b[2] = 8'h3C;
    @(posedge clk); #1;
    accept_q.delete();
    for (int i = 0; i < 3; i++) begin
      req_valid = 1; req_mode = b2b_m[i]; req_a = b2b_a[i]; req_b = b2b_b[i];
      guard = 0;
      @(negedge clk);
      while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
      @(posedge clk); #1;
    end
    req_valid = 0;
    repeat (5) @(negedge clk);
    check("b2b_accepts", 32'(accept_q.size()), 32'd3);
    if (accept_q.size() == 3) begin
      check("b2b_gap0", 32'(accept_q[1] - accept_q[0]), 32'd4);
      check("b2b_gap1", 32'(accept_q[2] - accept_q[1]), 32'd4);
    end

    // Random phase: random ops, operands, gaps and response backpressure.
    rand_rdy = 1;
    for (int i = 0; i < 150; i++) begin
      alu_op_t m;
      logic [7:0] a, b;
      m = alu_op_t'($urandom_range(0, 8));
      a = 8'($urandom);
      b = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      do_op(m, a, b, res, d0, lat);
    end
    rand_rdy = 0;
    @(posedge clk); #1 rsp_ready = 1;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
